// File: rtl/axis_rr_arbiter_pkg.sv
// Shared definitions for the AXI-S round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE picks a port, GRANT streams it)
//   REL_*       : values of PACKET_MODE (grant release policy)
//   bits_for()  : counter width helper that never returns zero
package axis_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int REL_BURST  = 0;  // release on burst limit or valid drop
    localparam int REL_PACKET = 1;  // release on accepted tlast

    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder (combinational).
//   req  in  N    request vector
//   last in  LB   index of the previous winner; search starts at last+1
//   any  out 1    at least one request is set
//   idx  out LB   winning index (valid only when any=1)
// Requests are rotated so that last+1 sits at bit 0, the first set bit is
// found, and the offset is rotated back into a port index.
module rr_prio_enc #(
    parameter int N  = 4,
    parameter int LB = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LB-1:0] last,
    output logic          any,
    output logic [LB-1:0] idx
);

    logic [N-1:0]  rot;
    logic [LB-1:0] ofs;
    int            src;
    int            sum;

    always_comb begin
        rot = '0;
        src = 0;
        for (int k = 0; k < N; k++) begin
            src = int'(last) + 1 + k;
            if (src >= N) src = src - N;
            if (src >= N) src = src - N;
            rot[k] = req[LB'(src)];
        end
    end

    always_comb begin
        ofs = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) ofs = LB'(k);
        end
    end

    always_comb begin
        sum = int'(last) + 1 + int'(ofs);
        if (sum >= N) sum = sum - N;
        if (sum >= N) sum = sum - N;
        idx = LB'(sum);
    end

    assign any = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-S arbiter: PORTS requesters share one sink (typically the
// write side of a CDC FIFO). A grant is locked for a whole packet
// (PACKET_MODE=1) or for up to MAX_BURST beats / until valid drops
// (PACKET_MODE=0). Every output beat carries its source port in m_tx_tid.
//   clk, rst_n      clock, async active-low reset
//   cfg_en          per-port enable, looked at only when picking a port
//   s_rx_*          PORTS slave streams, port i data at [i*WIDTH +: WIDTH]
//   m_tx_*          registered master stream with tid
//   stat_busy       high while a port holds the grant
module axis_rr_arbiter
    import axis_rr_arbiter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PORTS       = 4,
    parameter int PORT_BITS   = $clog2(PORTS),
    parameter int PACKET_MODE = 1,
    parameter int MAX_BURST   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PORTS-1:0]       cfg_en,
    input  logic [PORTS*WIDTH-1:0] s_rx_tdata,
    input  logic [PORTS-1:0]       s_rx_tvalid,
    input  logic [PORTS-1:0]       s_rx_tlast,
    output logic [PORTS-1:0]       s_rx_tready,
    output logic [WIDTH-1:0]       m_tx_tdata,
    output logic                   m_tx_tlast,
    output logic [PORT_BITS-1:0]   m_tx_tid,
    output logic                   m_tx_tvalid,
    input  logic                   m_tx_tready,
    output logic                   stat_busy
);

    localparam int BURST_BITS = bits_for(MAX_BURST + 1);
    localparam logic [BURST_BITS-1:0] BURST_LAST =
        BURST_BITS'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    arb_state_e                  state;
    logic [PORT_BITS-1:0]        grant;
    logic [PORT_BITS-1:0]        last_grant;
    logic [BURST_BITS-1:0]       beat_cnt;

    logic [PORTS-1:0]            req;
    logic                        pick_any;
    logic [PORT_BITS-1:0]        pick_idx;
    logic [PORTS-1:0][WIDTH-1:0] rx_data;
    logic                        in_grant;
    logic                        out_free;
    logic                        gnt_valid;
    logic                        gnt_last;
    logic                        accept;
    logic                        burst_end;
    logic                        release_now;

    assign req      = s_rx_tvalid & cfg_en;
    assign rx_data  = s_rx_tdata;
    assign in_grant = (state == ST_GRANT);
    // Single output register: it can take a beat when empty or draining.
    assign out_free = ~m_tx_tvalid | m_tx_tready;

    rr_prio_enc #(.N(PORTS), .LB(PORT_BITS)) u_enc (
        .req  (req),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign gnt_valid = s_rx_tvalid[grant];
    assign gnt_last  = s_rx_tlast[grant];
    assign accept    = in_grant & gnt_valid & out_free;
    assign burst_end = (MAX_BURST != 0) && (beat_cnt == BURST_LAST);

    always_comb begin
        release_now = 1'b0;
        if (in_grant) begin
            if (PACKET_MODE != REL_BURST)
                release_now = accept & gnt_last;
            else
                release_now = (accept & burst_end) | ~gnt_valid;
        end
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_rdy
        assign s_rx_tready[g] = in_grant & (grant == PORT_BITS'(g)) & out_free;
    end

    assign stat_busy = in_grant;

    // Arbiter FSM. last_grant resets to PORTS-1 so port 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= PORT_BITS'(PORTS - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        beat_cnt   <= '0;
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Saturate rather than wrap in unlimited-burst mode.
                    if (accept && (beat_cnt != '1))
                        beat_cnt <= beat_cnt + 1'b1;
                    if (release_now)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register: holds while stalled, clears once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tx_tvalid <= 1'b0;
            m_tx_tdata  <= '0;
            m_tx_tlast  <= 1'b0;
            m_tx_tid    <= '0;
        end else if (accept) begin
            m_tx_tvalid <= 1'b1;
            m_tx_tdata  <= rx_data[grant];
            m_tx_tlast  <= gnt_last;
            m_tx_tid    <= grant;
        end else if (m_tx_tready) begin
            m_tx_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;

    localparam int W  = 32;
    localparam int P  = 4;
    localparam int PB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [P-1:0]   cfg_en;
    logic [P*W-1:0] s_data;
    logic [P-1:0]   s_valid, s_last, s_ready;
    logic [W-1:0]   m_data;
    logic           m_last, m_valid, m_ready, busy;
    logic [PB-1:0]  m_tid;

    logic [P*W-1:0] b_data;
    logic [P-1:0]   b_valid, b_last, b_ready;
    logic [W-1:0]   bm_data;
    logic           bm_last, bm_valid, b_busy;
    logic [PB-1:0]  bm_tid;

    axis_rr_arbiter #(.WIDTH(W), .PORTS(P), .PACKET_MODE(1), .MAX_BURST(16)) u_pkt (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
        .s_rx_tdata(s_data), .s_rx_tvalid(s_valid), .s_rx_tlast(s_last), .s_rx_tready(s_ready),
        .m_tx_tdata(m_data), .m_tx_tlast(m_last), .m_tx_tid(m_tid), .m_tx_tvalid(m_valid),
        .m_tx_tready(m_ready), .stat_busy(busy)
    );

    axis_rr_arbiter #(.WIDTH(W), .PORTS(P), .PACKET_MODE(0), .MAX_BURST(4)) u_bst (
        .clk(clk), .rst_n(rst_n), .cfg_en(4'b1111),
        .s_rx_tdata(b_data), .s_rx_tvalid(b_valid), .s_rx_tlast(b_last), .s_rx_tready(b_ready),
        .m_tx_tdata(bm_data), .m_tx_tlast(bm_last), .m_tx_tid(bm_tid), .m_tx_tvalid(bm_valid),
        .m_tx_tready(1'b1), .stat_busy(b_busy)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           gap;
    } beat_t;

    beat_t src_q[P][$];
    beat_t exp_q[P][$];
    beat_t b_src_q[$];
    int    exp_gnt_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pkt_cnt[P];
    int beats = 0;
    int first_cyc = -1;
    int last_cyc = 0;
    int pushed = 0;
    bit rnd_ready = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push_pkt(input int p, input int len, input int gap_at, input int gap_len, input bit rnd_gap);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.last = (i == len - 1);
            b.gap  = (i == gap_at) ? gap_len : 0;
            if (rnd_gap && ($urandom_range(0, 3) == 0)) b.gap = $urandom_range(1, 3);
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
            pushed++;
        end
    endtask

    // Stimulus drivers: handshakes are sampled mid-cycle, inputs change just after posedge.
    initial begin : src_drv
        logic [P-1:0] hsv;
        s_valid = '0; s_data = '0; s_last = '0;
        forever begin
            @(negedge clk);
            hsv = s_valid & s_ready;
            @(posedge clk); #1;
            for (int p = 0; p < P; p++) begin
                if (hsv[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0 && src_q[p][0].gap > 0) begin
                    s_valid[p] = 1'b0;
                    src_q[p][0].gap = src_q[p][0].gap - 1;
                end else if (src_q[p].size() > 0) begin
                    s_valid[p]          = 1'b1;
                    s_data[p*W +: W]    = src_q[p][0].data;
                    s_last[p]           = src_q[p][0].last;
                end else begin
                    s_valid[p] = 1'b0;
                end
            end
        end
    end

    initial begin : b_drv
        bit hsb;
        b_valid = '0; b_data = '0; b_last = '0;
        forever begin
            @(negedge clk);
            hsb = b_valid[1] & b_ready[1];
            @(posedge clk); #1;
            if (hsb && b_src_q.size() > 0) void'(b_src_q.pop_front());
            if (b_src_q.size() > 0) begin
                b_valid[1]    = 1'b1;
                b_data[W +: W] = b_src_q[0].data;
                b_last[1]     = b_src_q[0].last;
            end else begin
                b_valid[1] = 1'b0;
            end
        end
    end

    initial begin : sink_drv
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin : mon
        bit            in_pkt, hold;
        logic [35:0]   held;
        int            t;
        beat_t         e;
        in_pkt = 0; hold = 0; held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_pkt = 0;
                hold   = 0;
            end else begin
                chk("ready_onehot", 64'($countones(s_ready) <= 1), 64'd1);
                if (hold) chk("hold_stable", 64'({m_valid, m_last, m_tid, m_data}), 64'(held));
                hold = m_valid && !m_ready;
                held = {m_valid, m_last, m_tid, m_data};
                if (m_valid && m_ready) begin
                    t = int'(m_tid);
                    if (!in_pkt) begin
                        pkt_cnt[t]++;
                        if (exp_gnt_q.size() > 0) chk("grant_order", 64'(t), 64'(exp_gnt_q.pop_front()));
                    end
                    if (exp_q[t].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: tid %0d data %0h, expected no beat", t, m_data);
                    end else begin
                        e = exp_q[t].pop_front();
                        chk("beat_data", 64'(m_data), 64'(e.data));
                        chk("beat_last", 64'(m_last), 64'(e.last));
                    end
                    in_pkt = !m_last;
                    beats++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end
        end
    end

    task automatic reset_dut();
        @(posedge clk); #2;
        rst_n = 1'b0;
        for (int p = 0; p < P; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
            pkt_cnt[p] = 0;
        end
        b_src_q.delete();
        exp_gnt_q.delete();
        beats = 0; pushed = 0; first_cyc = -1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input logic [P-1:0] mask, input int budget, input string nm);
        int n;
        bit done;
        done = 0;
        for (n = 0; n < budget && !done; n++) begin
            @(posedge clk); #2;
            done = (exp_gnt_q.size() == 0);
            for (int p = 0; p < P; p++) if (mask[p] && exp_q[p].size() != 0) done = 0;
        end
        chk({nm, "_drain_timeout"}, 64'(done), 64'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [11:0] pat;
        logic [3:0]  tail;
        int          n, bi;
        rst_n  = 1'b0;
        cfg_en = 4'b1111;
        #12;
        // ---- 1: reset state, mid-stream reset, first grants
        chk("rst_tvalid", 64'(m_valid), 64'd0);
        chk("rst_tready", 64'(s_ready), 64'd0);
        chk("rst_busy",   64'(busy),    64'd0);
        reset_dut();
        for (int p = 0; p < 3; p++) push_pkt(p, 4, -1, 0, 0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 64'(m_valid), 64'd0);
        chk("midrst_tdata",  64'(m_data),  64'd0);
        chk("midrst_tlast",  64'(m_last),  64'd0);
        chk("midrst_tid",    64'(m_tid),   64'd0);
        chk("midrst_tready", 64'(s_ready), 64'd0);
        chk("midrst_busy",   64'(busy),    64'd0);
        reset_dut();
        for (int p = 0; p < P; p++) begin
            push_pkt(p, 1, -1, 0, 0);
            exp_gnt_q.push_back(p);
        end
        wait_drain(4'b1111, 100, "t1");

        // ---- 2: fairness, 1000 packets of 3 beats, one idle cycle per packet
        reset_dut();
        for (int k = 0; k < 250; k++)
            for (int p = 0; p < P; p++) begin
                push_pkt(p, 3, -1, 0, 0);
                exp_gnt_q.push_back(p);
            end
        wait_drain(4'b1111, 6000, "t2");
        for (int p = 0; p < P; p++) chk("t2_pkts_per_port", 64'(pkt_cnt[p]), 64'd250);
        chk("t2_span_cycles", 64'(last_cyc - first_cyc + 1), 64'd3999);

        // ---- 3: random traffic with random backpressure
        reset_dut();
        rnd_ready = 1;
        for (int k = 0; k < 150; k++)
            push_pkt($urandom_range(0, P - 1), $urandom_range(1, 5), -1, 0, 1);
        wait_drain(4'b1111, 20000, "t3");
        chk("t3_beat_total", 64'(beats), 64'(pushed));
        rnd_ready = 0;

        // ---- 4: burst mode, port 1 alone, 10 beats -> 4,4,2
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            beat_t b;
            b.data = 32'h100 + i;
            b.last = (i == 2);
            b.gap  = 0;
            b_src_q.push_back(b);
        end
        n = 0;
        while (!bm_valid && n < 40) begin @(negedge clk); n++; end
        chk("t4_first_valid_timeout", 64'(bm_valid), 64'd1);
        pat = '0; bi = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            pat = {pat[10:0], bm_valid};
            chk("t4_ready_other_ports", 64'(b_ready & 4'b1101), 64'd0);
            if (bm_valid) begin
                chk("t4_tid",   64'(bm_tid),  64'd1);
                chk("t4_data",  64'(bm_data), 64'(32'h100 + bi));
                chk("t4_tlast", 64'(bm_last), 64'(bi == 2));
                bi++;
            end
        end
        tail = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tail = {tail[2:0], bm_valid};
        end
        chk("t4_valid_pattern", 64'(pat), 64'(12'b1111_0_1111_0_11));
        chk("t4_tail_idle", 64'(tail), 64'd0);
        chk("t4_busy_after", 64'(b_busy), 64'd0);

        // ---- 5a: mask 1011, port 2 never granted
        cfg_en = 4'b1011;
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < P; p++) push_pkt(p, 2, -1, 0, 0);
            exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(3);
        end
        wait_drain(4'b1011, 400, "t5a");
        repeat (10) @(posedge clk);
        chk("t5a_port2_pkts", 64'(pkt_cnt[2]), 64'd0);
        chk("t5a_port2_left", 64'(exp_q[2].size()), 64'd6);

        // ---- 5b: clear enable of port 0 during its grant
        cfg_en = 4'b1111;
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            push_pkt(0, 6, -1, 0, 0);
            push_pkt(1, 6, -1, 0, 0);
            push_pkt(3, 6, -1, 0, 0);
        end
        exp_gnt_q = '{0, 1, 3, 1, 3};
        repeat (3) @(posedge clk);
        #2;
        chk("t5b_busy_at_clear", 64'(busy), 64'd1);
        cfg_en = 4'b1010;
        wait_drain(4'b1010, 400, "t5b");
        repeat (10) @(posedge clk);
        chk("t5b_port0_pkts", 64'(pkt_cnt[0]), 64'd1);
        chk("t5b_port0_left", 64'(exp_q[0].size()), 64'd6);

        // ---- 6: valid gap inside port 3's packet holds the grant
        cfg_en = 4'b1111;
        reset_dut();
        push_pkt(3, 6, 3, 5, 0);
        exp_gnt_q = '{3, 0};
        repeat (3) @(posedge clk);
        #2 push_pkt(0, 3, -1, 0, 0);
        repeat (6) @(posedge clk);
        #2 chk("t6_busy_in_gap", 64'(busy), 64'd1);
        wait_drain(4'b1111, 200, "t6");
        chk("t6_pkts_port3", 64'(pkt_cnt[3]), 64'd1);
        chk("t6_pkts_port0", 64'(pkt_cnt[0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
